wb_completion_monitor: RTL and testbench

- Synthesizable end-of-test detector placed directly downstream of the RISC_V_02 register-file writeback port.
- Consumes each writeback (address/data), keeps cycle and write statistics, and decides PASS/FAIL when the signature register is written.
- Includes a watchdog that flags a hung program.
- Drives a halt request and status flags that the bench and future FPGA top use instead of ad-hoc $finish checks.

---
 rtl/wb_completion_monitor.sv | 113 +++++++++++
 tb/tb_wb_completion_monitor.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/wb_completion_monitor.sv
// End-of-test detector sitting on the register-file writeback port.
// It tracks cycles and writes in RUN, and latches PASS, FAIL or TIMEOUT.
module wb_completion_monitor #(
    parameter int unsigned DONE_REG       = 12,
    parameter logic [31:0] PASS_VALUE     = 32'd1,
    parameter int unsigned TIMEOUT_CYCLES = 10000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             reg_write_en,
    input  logic [4:0]       reg_writeaddr,
    input  logic [31:0]      reg_writedata,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic             halt_req,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] write_count,
    output logic [4:0]       last_addr,
    output logic [31:0]      last_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    localparam logic [4:0]       DONE_ADDR = 5'(DONE_REG);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit               WD_EN     = (TIMEOUT_CYCLES != 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0] write_count_q, write_count_d;
    logic [4:0]       last_addr_q, last_addr_d;
    logic [31:0]      last_data_q, last_data_d;

    logic qual_wr, term_wr, wd_hit;

    always_comb begin
        qual_wr = reg_write_en && (reg_writeaddr != 5'd0);
        term_wr = qual_wr && (reg_writeaddr == DONE_ADDR);
        wd_hit  = WD_EN && (cycle_count_q == WD_LAST);

        state_d       = state_q;
        cycle_count_d = cycle_count_q;
        write_count_d = write_count_q;
        last_addr_d   = last_addr_q;
        last_data_d   = last_data_q;

        // start re-arms from any state and drops the current writeback
        if (start) begin
            state_d       = S_RUN;
            cycle_count_d = '0;
            write_count_d = '0;
            last_addr_d   = '0;
            last_data_d   = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (cycle_count_q != CNT_MAX)
                        cycle_count_d = cycle_count_q + CNT_W'(1);
                    if (qual_wr) begin
                        if (write_count_q != CNT_MAX)
                            write_count_d = write_count_q + CNT_W'(1);
                        last_addr_d = reg_writeaddr;
                        last_data_d = reg_writedata;
                    end
                    // a terminating write beats a watchdog expiry in the same cycle
                    if (term_wr)
                        state_d = (reg_writedata == PASS_VALUE) ? S_PASS : S_FAIL;
                    else if (wd_hit)
                        state_d = S_TIMEOUT;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cycle_count_q <= '0;
            write_count_q <= '0;
            last_addr_q   <= '0;
            last_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            cycle_count_q <= cycle_count_d;
            write_count_q <= write_count_d;
            last_addr_q   <= last_addr_d;
            last_data_q   <= last_data_d;
        end
    end

    assign pass        = (state_q == S_PASS);
    assign fail        = (state_q == S_FAIL);
    assign timeout     = (state_q == S_TIMEOUT);
    assign done        = pass | fail | timeout;
    assign halt_req    = done;
    assign cycle_count = cycle_count_q;
    assign write_count = write_count_q;
    assign last_addr   = last_addr_q;
    assign last_data   = last_data_q;

endmodule

// File: tb/tb_wb_completion_monitor.sv
// Directed bench: a vector table for pass/fail/x0 flows, then hand sequences
// for watchdog, reset, restart and counter saturation.
module tb_wb_completion_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] data = '0;

    logic        done, pass, fail, timeout, halt_req;
    logic [31:0] cycle_count, write_count;
    logic [4:0]  last_addr;
    logic [31:0] last_data;

    logic        s_done, s_pass, s_fail, s_timeout, s_halt;
    logic [3:0]  s_cc, s_wc;
    logic [4:0]  s_la;
    logic [31:0] s_ld;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_completion_monitor #(.DONE_REG(12), .PASS_VALUE(32'd1), .TIMEOUT_CYCLES(20), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .reg_write_en(we),
        .reg_writeaddr(addr), .reg_writedata(data),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout), .halt_req(halt_req),
        .cycle_count(cycle_count), .write_count(write_count),
        .last_addr(last_addr), .last_data(last_data)
    );

    wb_completion_monitor #(.DONE_REG(12), .PASS_VALUE(32'd1), .TIMEOUT_CYCLES(0), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .reg_write_en(we),
        .reg_writeaddr(addr), .reg_writedata(data),
        .done(s_done), .pass(s_pass), .fail(s_fail), .timeout(s_timeout), .halt_req(s_halt),
        .cycle_count(s_cc), .write_count(s_wc),
        .last_addr(s_la), .last_data(s_ld)
    );

    typedef struct {
        logic        st;
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
        logic        e_done;
        logic        e_pass;
        logic        e_fail;
        logic        e_to;
        logic [31:0] e_cc;
        logic [31:0] e_wc;
        logic [4:0]  e_la;
        logic [31:0] e_ld;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_done, input logic e_pass,
                           input logic e_fail, input logic e_to, input logic [31:0] e_cc,
                           input logic [31:0] e_wc, input logic [4:0] e_la, input logic [31:0] e_ld);
        chk({tag, ".done"},     32'(done),      32'(e_done));
        chk({tag, ".halt_req"}, 32'(halt_req),  32'(e_done));
        chk({tag, ".pass"},     32'(pass),      32'(e_pass));
        chk({tag, ".fail"},     32'(fail),      32'(e_fail));
        chk({tag, ".timeout"},  32'(timeout),   32'(e_to));
        chk({tag, ".cycles"},   cycle_count,    e_cc);
        chk({tag, ".writes"},   write_count,    e_wc);
        chk({tag, ".last_addr"}, 32'(last_addr), 32'(e_la));
        chk({tag, ".last_data"}, last_data,     e_ld);
    endtask

    // one clock: drive at negedge, sample 1 time unit after the rising edge
    task automatic cyc(input logic st, input logic w, input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        start = st; we = w; addr = a; data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //               st we  a   d             done pass fail to  cc  wc  la  ld
        vecs[0]  = '{1'b1, 1'b0, 5'd0,  32'd0,      1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0,  32'd0};
        vecs[1]  = '{1'b0, 1'b1, 5'd5,  32'd7,      1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1, 5'd5,  32'd7};
        vecs[2]  = '{1'b0, 1'b1, 5'd6,  32'd9,      1'b0, 1'b0, 1'b0, 1'b0, 32'd2, 32'd2, 5'd6,  32'd9};
        vecs[3]  = '{1'b0, 1'b1, 5'd12, 32'd1,      1'b1, 1'b1, 1'b0, 1'b0, 32'd3, 32'd3, 5'd12, 32'd1};
        vecs[4]  = '{1'b0, 1'b0, 5'd0,  32'd0,      1'b1, 1'b1, 1'b0, 1'b0, 32'd3, 32'd3, 5'd12, 32'd1};
        vecs[5]  = '{1'b0, 1'b1, 5'd7,  32'd5,      1'b1, 1'b1, 1'b0, 1'b0, 32'd3, 32'd3, 5'd12, 32'd1};
        vecs[6]  = '{1'b1, 1'b0, 5'd0,  32'd0,      1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0,  32'd0};
        vecs[7]  = '{1'b0, 1'b1, 5'd12, 32'hDEAD,   1'b1, 1'b0, 1'b1, 1'b0, 32'd1, 32'd1, 5'd12, 32'hDEAD};
        vecs[8]  = '{1'b0, 1'b1, 5'd12, 32'd1,      1'b1, 1'b0, 1'b1, 1'b0, 32'd1, 32'd1, 5'd12, 32'hDEAD};
        vecs[9]  = '{1'b1, 1'b0, 5'd0,  32'd0,      1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0,  32'd0};
        vecs[10] = '{1'b0, 1'b1, 5'd0,  32'd1,      1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd0, 5'd0,  32'd0};
        vecs[11] = '{1'b0, 1'b0, 5'd12, 32'd1,      1'b0, 1'b0, 1'b0, 1'b0, 32'd2, 32'd0, 5'd0,  32'd0};
        vecs[12] = '{1'b1, 1'b1, 5'd12, 32'd1,      1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0,  32'd0};

        // reset held for two cycles
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        // idle before any start: writes ignored
        cyc(0, 1, 5'd12, 32'd1);
        chk_all("idle", 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 13; i++) begin
            cyc(vecs[i].st, vecs[i].we, vecs[i].a, vecs[i].d);
            chk_all($sformatf("vec%0d", i), vecs[i].e_done, vecs[i].e_pass, vecs[i].e_fail,
                    vecs[i].e_to, vecs[i].e_cc, vecs[i].e_wc, vecs[i].e_la, vecs[i].e_ld);
        end

        // watchdog: 20 RUN cycles with no writes
        cyc(1, 0, 0, 0);
        for (int i = 1; i <= 19; i++) cyc(0, 0, 0, 0);
        chk_all("wd19", 0, 0, 0, 0, 19, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk_all("wd20", 1, 0, 0, 1, 20, 0, 0, 0);
        cyc(0, 1, 5'd12, 32'd1);
        chk_all("wd_hold", 1, 0, 0, 1, 20, 0, 0, 0);

        // pass write on the expiry cycle wins over the watchdog
        cyc(1, 0, 0, 0);
        for (int i = 1; i <= 19; i++) cyc(0, 0, 0, 0);
        cyc(0, 1, 5'd12, 32'd1);
        chk_all("wd_race", 1, 1, 0, 0, 20, 1, 5'd12, 32'd1);

        // reset in the middle of a run
        cyc(1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) cyc(0, 1, 5'(i), 32'(i * 3));
        chk_all("pre_rst", 0, 0, 0, 0, 4, 4, 5'd4, 32'd12);
        @(negedge clk);
        reset = 1'b0; start = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk_all("mid_rst", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        cyc(0, 1, 5'd12, 32'd1);
        cyc(0, 1, 5'd3, 32'd4);
        chk_all("post_rst", 0, 0, 0, 0, 0, 0, 0, 0);

        // pass, then start re-arms into RUN
        cyc(1, 0, 0, 0);
        cyc(0, 1, 5'd12, 32'd1);
        chk_all("pass2", 1, 1, 0, 0, 1, 1, 5'd12, 32'd1);
        cyc(1, 0, 0, 0);
        chk_all("rearm", 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk_all("rearm_run", 0, 0, 0, 0, 1, 0, 0, 0);

        // saturation on the 4-bit, watchdog-free instance
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 1, 5'd3, 32'(i));
        chk("sat.cycles", 32'(s_cc), 32'hF);
        chk("sat.writes", 32'(s_wc), 32'hF);
        chk("sat.done", 32'(s_done), 32'd0);
        chk("sat.flags", 32'({s_pass, s_fail, s_timeout, s_halt}), 32'd0);
        chk("sat.last", {s_la, s_ld[26:0]}, {5'd3, 27'd19});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
